// File: rtl/cat_recognizer_pkg.sv
// -----------------------------------------------------------------------------
// cat_recognizer_pkg
// Shared definitions for the cat_recognizer blocks:
//   apb_state_t     - APB slave protocol state (IDLE / SETUP / ACCESS)
//   CTRL_ADDR       - APB address of the control/status register
//   STAT_*          - bit positions inside the status word returned at CTRL_ADDR
//   CTRL_START_BIT  - control write bit that launches a calculation
// -----------------------------------------------------------------------------
package cat_recognizer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam int CTRL_ADDR      = 0;

  // Status word layout: {0.., wr_cnt at [STAT_CNT_LSB +: addr width], result, done, busy}
  localparam int STAT_BUSY      = 0;
  localparam int STAT_DONE      = 1;
  localparam int STAT_RESULT    = 2;
  localparam int STAT_CNT_LSB   = 3;

  localparam int CTRL_START_BIT = 0;

endpackage

// File: rtl/apb_image_slave_if.sv
// -----------------------------------------------------------------------------
// apb_image_slave_if
// APB bus bundle between the stimulus master and apb_image_slave.
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA : master -> slave
//   PRDATA, PREADY, PSLVERR              : slave  -> master
//
// Handshake: a transfer is a setup phase (PSEL=1, PENABLE=0) followed by an
// access phase (PSEL=1, PENABLE=1). The master holds address, direction and
// write data stable from setup until it observes PREADY=1; that cycle is the
// single completing cycle, and PRDATA/PSLVERR are only meaningful in it.
// -----------------------------------------------------------------------------
interface apb_image_slave_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 24
) ();

  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/image_dpram.sv
// -----------------------------------------------------------------------------
// image_dpram
// Image word store: one synchronous write port and two synchronous read ports.
//   clk, rst     : clock, asynchronous active-low reset (read registers only)
//   we_i, waddr_i, wdata_i : write port (APB side)
//   a_raddr_i -> a_rdata_o : APB read port, 1-cycle latency, read-first
//   b_ren_i, b_raddr_i -> b_rdata_o : core read port, 1-cycle latency;
//                            returns 0 when b_ren_i is low (address out of range)
// The array itself is never reset; only the read registers are.
// -----------------------------------------------------------------------------
module image_dpram #(
  parameter  int Amba_Word   = 24,
  parameter  int file_length = 4096,
  localparam int AW          = $clog2(file_length)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we_i,
  input  logic [AW-1:0]        waddr_i,
  input  logic [Amba_Word-1:0] wdata_i,
  input  logic [AW-1:0]        a_raddr_i,
  output logic [Amba_Word-1:0] a_rdata_o,
  input  logic                 b_ren_i,
  input  logic [AW-1:0]        b_raddr_i,
  output logic [Amba_Word-1:0] b_rdata_o
);

  logic [Amba_Word-1:0] mem [file_length];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Both reads sample the array before this edge's write lands, so a
  // read-during-write to the same word returns the old contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_rdata_o <= '0;
      b_rdata_o <= '0;
    end else begin
      a_rdata_o <= mem[a_raddr_i];
      b_rdata_o <= b_ren_i ? mem[b_raddr_i] : '0;
    end
  end

endmodule

// File: rtl/apb_image_slave.sv
// -----------------------------------------------------------------------------
// apb_image_slave
// APB slave in front of the cat recognizer core.
//   clk, rst      : clock, asynchronous active-low reset
//   bus (slave)   : APB port; addr 0 = control/status, addr 1..file_length =
//                   image words (three 8-bit pixels per word)
//   core_rd_addr  : core image-word index; core_rd_data returns it 1 cycle later
//   core_start    : one-cycle pulse launching a calculation
//   core_done     : one-cycle completion pulse, core_result sampled with it
//   busy          : calculation in progress
//   dbg_state_o   : current APB protocol state
//
// Transfer timing: the FSM leaves IDLE when it sees a setup phase, latches the
// response (PRDATA, PSLVERR) at the end of SETUP, and shows it with PREADY=1 for
// exactly one ACCESS cycle. Side effects commit at the end of that ACCESS cycle
// using the error decision taken at the end of SETUP, so the reported PSLVERR
// and the committed action can never disagree.
// -----------------------------------------------------------------------------
module apb_image_slave
  import cat_recognizer_pkg::*;
#(
  parameter int Amba_Word        = 24,
  parameter int Amba_Addr_Depth  = 13,
  parameter int Weight_precision = 5,
  parameter int file_length      = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  apb_image_slave_if.slave           bus,
  input  logic [Amba_Addr_Depth-2:0] core_rd_addr,
  output logic [Amba_Word-1:0]       core_rd_data,
  output logic                       core_start,
  input  logic                       core_done,
  input  logic                       core_result,
  output logic                       busy,
  output apb_state_t                 dbg_state_o
);

  localparam int IMG_AW = $clog2(file_length);
  localparam logic [Amba_Addr_Depth-1:0] FILE_LEN_A = Amba_Addr_Depth'(file_length);
  localparam logic [Amba_Addr_Depth-1:0] CTRL_A     = Amba_Addr_Depth'(CTRL_ADDR);
  localparam logic [Amba_Addr_Depth-1:0] ONE_A      = Amba_Addr_Depth'(1);

  // Weight_precision only keeps the parameter set uniform across blocks.
  if (Weight_precision < 1) begin : g_wp_guard
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  apb_state_t                 state_q;
  logic                       pready_q;
  logic                       pslverr_q;
  logic [Amba_Word-1:0]       prdata_q;
  logic                       core_start_q;
  logic                       busy_q;
  logic                       done_q;
  logic                       result_q;
  logic [Amba_Addr_Depth-1:0] wr_cnt_q;

  // ---------------------------------------------------------------------------
  // Decode of the transfer currently on the bus
  // ---------------------------------------------------------------------------
  logic                 addr_is_ctrl;
  logic                 addr_oob;
  logic                 start_req;
  logic                 err_d;
  logic                 commit;
  logic                 img_we;
  logic                 core_ren;
  logic [Amba_Word-1:0] status;
  logic [Amba_Word-1:0] apb_rdata;
  logic [Amba_Word-1:0] prdata_d;

  assign addr_is_ctrl = (bus.PADDR == CTRL_A);
  assign addr_oob     = (bus.PADDR > FILE_LEN_A);
  assign start_req    = bus.PWDATA[CTRL_START_BIT];

  // Any write while busy is refused except a control write that only clears.
  assign err_d = addr_oob |
                 (bus.PWRITE & busy_q & (~addr_is_ctrl | start_req));

  // PSLVERR in ACCESS holds the error decision for this very transfer.
  assign commit = (state_q == ACCESS) & bus.PWRITE & ~pslverr_q;
  assign img_we = commit & ~addr_is_ctrl;

  assign core_ren = ({1'b0, core_rd_addr} < FILE_LEN_A);

  always_comb begin
    status                                    = '0;
    status[STAT_BUSY]                         = busy_q;
    status[STAT_DONE]                         = done_q;
    status[STAT_RESULT]                       = result_q;
    status[STAT_CNT_LSB +: Amba_Addr_Depth]   = wr_cnt_q;
  end

  always_comb begin
    prdata_d = '0;
    if (!err_d && !bus.PWRITE) begin
      prdata_d = addr_is_ctrl ? status : apb_rdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Image memory. The APB read port is addressed straight from PADDR so the
  // word is already available during SETUP and can be latched into PRDATA.
  // ---------------------------------------------------------------------------
  image_dpram #(
    .Amba_Word   (Amba_Word),
    .file_length (file_length)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .we_i      (img_we),
    .waddr_i   (IMG_AW'(bus.PADDR - ONE_A)),
    .wdata_i   (bus.PWDATA),
    .a_raddr_i (IMG_AW'(bus.PADDR - ONE_A)),
    .a_rdata_o (apb_rdata),
    .b_ren_i   (core_ren),
    .b_raddr_i (IMG_AW'(core_rd_addr)),
    .b_rdata_o (core_rd_data)
  );

  // ---------------------------------------------------------------------------
  // APB FSM, response registers, control/status state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      pready_q     <= 1'b0;
      pslverr_q    <= 1'b0;
      prdata_q     <= '0;
      core_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      result_q     <= 1'b0;
      wr_cnt_q     <= '0;
    end else begin
      pready_q     <= 1'b0;
      pslverr_q    <= 1'b0;
      prdata_q     <= '0;
      core_start_q <= 1'b0;

      case (state_q)
        IDLE: begin
          // PENABLE still high after a finished transfer is not a new setup.
          if (bus.PSEL && !bus.PENABLE) begin
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (bus.PSEL && bus.PENABLE) begin
            state_q   <= ACCESS;
            pready_q  <= 1'b1;
            pslverr_q <= err_d;
            prdata_q  <= prdata_d;
          end else if (!bus.PSEL) begin
            state_q <= IDLE;
          end
        end
        ACCESS: begin
          state_q <= (bus.PSEL && !bus.PENABLE) ? SETUP : IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase

      if (commit) begin
        if (addr_is_ctrl) begin
          if (start_req) begin
            core_start_q <= 1'b1;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
          end else begin
            done_q   <= 1'b0;
            result_q <= 1'b0;
            wr_cnt_q <= '0;
          end
        end else if (wr_cnt_q != FILE_LEN_A) begin
          wr_cnt_q <= wr_cnt_q + ONE_A;
        end
      end

      // Placed last so a completion arriving with a clearing write still lands.
      if (core_done && busy_q) begin
        busy_q   <= 1'b0;
        done_q   <= 1'b1;
        result_q <= core_result;
      end
    end
  end

  assign bus.PRDATA  = prdata_q;
  assign bus.PREADY  = pready_q;
  assign bus.PSLVERR = pslverr_q;
  assign core_start  = core_start_q;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb_image_slave.sv
// -----------------------------------------------------------------------------
// tb_apb_image_slave
// Directed bench for apb_image_slave: a table of APB vectors with hand-computed
// PRDATA/PSLVERR, plus hand-written sequences for reset, start/done, error,
// held-PENABLE and full-image core read-back.
// -----------------------------------------------------------------------------
module tb_apb_image_slave;
  import cat_recognizer_pkg::*;

  localparam int AW = 13;
  localparam int DW = 24;
  localparam int FL = 4096;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  apb_image_slave_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  logic [AW-2:0] core_rd_addr;
  logic [DW-1:0] core_rd_data;
  logic          core_start;
  logic          core_done;
  logic          core_result;
  logic          busy;
  apb_state_t    dbg_state;

  apb_image_slave #(
    .Amba_Word        (DW),
    .Amba_Addr_Depth  (AW),
    .Weight_precision (5),
    .file_length      (FL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .core_rd_addr (core_rd_addr),
    .core_rd_data (core_rd_data),
    .core_start   (core_start),
    .core_done    (core_done),
    .core_result  (core_result),
    .busy         (busy),
    .dbg_state_o  (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard bookkeeping
  // ---------------------------------------------------------------------------
  int n_vec   = 0;
  int n_err   = 0;
  int n_start = 0;
  logic [DW-1:0] exp_q[$];

  always @(negedge clk) begin
    if (core_start === 1'b1) n_start++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] stat(input int cnt, input bit res, input bit dn, input bit bsy);
    return DW'((cnt << 3) | (int'(res) << 2) | (int'(dn) << 1) | int'(bsy));
  endfunction

  function automatic logic [DW-1:0] img_word(input int i);
    return DW'(i * 24'h010307 + 24'h0A0B0C);
  endfunction

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic apb_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input int hold, input logic pulse_done,
                          output logic [DW-1:0] rdata, output logic err);
    int waits;
    @(posedge clk); #1;
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = wr;
    bus.PADDR   = addr;
    bus.PWDATA  = wdata;
    @(posedge clk); #1;
    bus.PENABLE = 1'b1;
    if (pulse_done) core_done = 1'b1;
    waits = 0;
    do begin
      @(posedge clk); #1;
      core_done = 1'b0;
      waits++;
    end while (bus.PREADY !== 1'b1 && waits < 8);
    if (bus.PREADY !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL pready_timeout: got 0x%0h, expected 0x1", bus.PREADY);
    end
    rdata = bus.PRDATA;
    err   = bus.PSLVERR;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check("pready_held_penable", 32'(bus.PREADY), 32'(1'b0));
    end
    @(posedge clk); #1;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
  endtask

  task automatic xfer_chk(input string name, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rd, input logic exp_err);
    logic [DW-1:0] rd;
    logic          er;
    apb_xfer(wr, addr, wdata, 0, 1'b0, rd, er);
    check({name, "_prdata"}, 32'(rd), 32'(exp_rd));
    check({name, "_pslverr"}, 32'(er), 32'(exp_err));
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  initial begin : watchdog
    #1000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin : main
    logic [DW-1:0] rd;
    logic          er;

    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    bus.PADDR = '0;  bus.PWDATA = '0;
    core_rd_addr = '0; core_done = 1'b0; core_result = 1'b0;

    vecs[0]  = '{1'b1, 13'd1,    24'hA1B2C3, 24'h000000, 1'b0};
    vecs[1]  = '{1'b1, 13'd4096, 24'h010203, 24'h000000, 1'b0};
    vecs[2]  = '{1'b0, 13'd1,    24'h000000, 24'hA1B2C3, 1'b0};
    vecs[3]  = '{1'b0, 13'd4096, 24'h000000, 24'h010203, 1'b0};
    vecs[4]  = '{1'b0, 13'd0,    24'h000000, 24'h000010, 1'b0}; // wr_cnt=2
    vecs[5]  = '{1'b1, 13'd4097, 24'h123456, 24'h000000, 1'b1};
    vecs[6]  = '{1'b0, 13'd4097, 24'h000000, 24'h000000, 1'b1};
    vecs[7]  = '{1'b0, 13'h1FFF, 24'h000000, 24'h000000, 1'b1};
    vecs[8]  = '{1'b1, 13'd2,    24'h5A5A5A, 24'h000000, 1'b0};
    vecs[9]  = '{1'b0, 13'd2,    24'h000000, 24'h5A5A5A, 1'b0};
    vecs[10] = '{1'b0, 13'd0,    24'h000000, 24'h000018, 1'b0}; // wr_cnt=3
    vecs[11] = '{1'b0, 13'd1,    24'h000000, 24'hA1B2C3, 1'b0};
    vecs[12] = '{1'b1, 13'd0,    24'h000000, 24'h000000, 1'b0}; // clear
    vecs[13] = '{1'b0, 13'd0,    24'h000000, 24'h000000, 1'b0};
    vecs[14] = '{1'b0, 13'd4096, 24'h000000, 24'h010203, 1'b0};

    // --- reset state --------------------------------------------------------
    #12;
    check("rst_prdata",     32'(bus.PRDATA),  32'(0));
    check("rst_pready",     32'(bus.PREADY),  32'(0));
    check("rst_pslverr",    32'(bus.PSLVERR), 32'(0));
    check("rst_core_start", 32'(core_start),  32'(0));
    check("rst_busy",       32'(busy),        32'(0));
    check("rst_state",      32'(dbg_state),   32'(IDLE));
    check("rst_core_data",  32'(core_rd_data), 32'(0));
    @(negedge clk) rst = 1'b1;

    // --- asynchronous reset mid-calculation ---------------------------------
    xfer_chk("pre_wr1", 1'b1, 13'd1, 24'h111111, 24'h0, 1'b0);
    xfer_chk("pre_start", 1'b1, 13'd0, 24'h000001, 24'h0, 1'b0);
    check("pre_busy", 32'(busy), 32'(1));
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("async_busy",  32'(busy),       32'(0));
    check("async_start", 32'(core_start), 32'(0));
    check("async_state", 32'(dbg_state),  32'(IDLE));
    @(negedge clk) rst = 1'b1;
    xfer_chk("post_rst_status", 1'b0, 13'd0, 24'h0, 24'h000000, 1'b0);
    xfer_chk("post_rst_mem",    1'b0, 13'd1, 24'h0, 24'h111111, 1'b0);

    // --- table-driven transfers ---------------------------------------------
    for (int i = 0; i < NV; i++) begin
      apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 0, 1'b0, rd, er);
      check($sformatf("vec%0d_prdata", i),  32'(rd), 32'(vecs[i].exp_rdata));
      check($sformatf("vec%0d_pslverr", i), 32'(er), 32'(vecs[i].exp_err));
    end

    // --- start pulse and busy refusals --------------------------------------
    xfer_chk("wr5", 1'b1, 13'd5, 24'h0F0F0F, 24'h0, 1'b0);
    xfer_chk("start", 1'b1, 13'd0, 24'h000001, 24'h0, 1'b0);
    check("start_pulse_hi", 32'(core_start), 32'(1));
    check("start_busy",     32'(busy),       32'(1));
    @(posedge clk); #1;
    check("start_pulse_lo", 32'(core_start), 32'(0));
    check("start_busy_hold", 32'(busy),      32'(1));
    xfer_chk("busy_img_wr",  1'b1, 13'd5, 24'hDEADBE, 24'h0, 1'b1);
    xfer_chk("busy_start",   1'b1, 13'd0, 24'h000001, 24'h0, 1'b1);
    xfer_chk("busy_rd5",     1'b0, 13'd5, 24'h0, 24'h0F0F0F, 1'b0);
    xfer_chk("busy_status",  1'b0, 13'd0, 24'h0, stat(1, 1'b0, 1'b0, 1'b1), 1'b0);

    // --- completion ----------------------------------------------------------
    @(posedge clk); #1;
    core_done = 1'b1; core_result = 1'b1;
    @(posedge clk); #1;
    core_done = 1'b0; core_result = 1'b0;
    check("done_busy", 32'(busy), 32'(0));
    xfer_chk("done_status", 1'b0, 13'd0, 24'h0, 24'h00000E, 1'b0);
    xfer_chk("clear",       1'b1, 13'd0, 24'h0, 24'h0, 1'b0);
    xfer_chk("clr_status",  1'b0, 13'd0, 24'h0, 24'h000000, 1'b0);
    @(posedge clk); #1;
    core_done = 1'b1; core_result = 1'b1;
    @(posedge clk); #1;
    core_done = 1'b0; core_result = 1'b0;
    xfer_chk("stray_done_status", 1'b0, 13'd0, 24'h0, 24'h000000, 1'b0);

    // --- core_done coinciding with a start write ----------------------------
    xfer_chk("start2", 1'b1, 13'd0, 24'h000001, 24'h0, 1'b0);
    apb_xfer(1'b1, 13'd0, 24'h000001, 0, 1'b1, rd, er);
    check("race_pslverr", 32'(er), 32'(1));
    @(posedge clk); #1;
    check("race_busy", 32'(busy), 32'(0));
    xfer_chk("race_status", 1'b0, 13'd0, 24'h0, stat(0, 1'b0, 1'b1, 1'b0), 1'b0);

    // --- PENABLE held past the access cycle ----------------------------------
    apb_xfer(1'b1, 13'd7, 24'h777777, 2, 1'b0, rd, er);
    check("hold_pslverr", 32'(er), 32'(0));
    xfer_chk("hold_status", 1'b0, 13'd0, 24'h0, stat(1, 1'b0, 1'b1, 1'b0), 1'b0);
    xfer_chk("hold_rd7",    1'b0, 13'd7, 24'h0, 24'h777777, 1'b0);

    // --- full image load, saturation, core read-back ------------------------
    xfer_chk("img_clear", 1'b1, 13'd0, 24'h0, 24'h0, 1'b0);
    for (int i = 0; i < FL; i++) begin
      apb_xfer(1'b1, AW'(i + 1), img_word(i), 0, 1'b0, rd, er);
      check("img_wr_pslverr", 32'(er), 32'(0));
    end
    xfer_chk("full_status", 1'b0, 13'd0, 24'h0, 24'h008000, 1'b0);
    xfer_chk("sat_wr",      1'b1, 13'd3, img_word(2), 24'h0, 1'b0);
    xfer_chk("sat_status",  1'b0, 13'd0, 24'h0, 24'h008000, 1'b0);
    xfer_chk("img_start",   1'b1, 13'd0, 24'h000001, 24'h0, 1'b0);
    check("img_busy", 32'(busy), 32'(1));
    for (int i = 0; i <= FL; i++) begin
      @(posedge clk); #1;
      if (i > 0) check("core_rd_data", 32'(core_rd_data), 32'(exp_q.pop_front()));
      if (i < FL) begin
        core_rd_addr = (AW-1)'(i);
        exp_q.push_back(img_word(i));
      end
    end

    @(posedge clk); #1;
    check("start_pulse_count", 32'(n_start), 32'(4));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
